// File: rtl/io_led_sequencer.sv
// rtl/io_led_sequencer.sv - Wishbone LED/button sequencer; optional button irq under BTN_IRQ_EN
module io_led_sequencer #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DEB_CYCLES = 16,
    parameter logic [23:0] DEF_PERIOD = 24'd1000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  btn_i,
    output logic [7:0]  led_o,
    output logic [7:0]  led_oeb_o,
    output logic        irq_o
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_PAUSE} state_t;

    state_t         state, next_state;
    logic [2:0]     ctrl;
    logic [7:0]     led_data;
    logic [23:0]    period;
    logic [23:0]    tcnt;
    logic [7:0]     chase_pat, count_pat;
    logic [2:0]     sync1, sync2, btn_db;
    logic [DW-1:0]  dcnt [3];
    logic [7:0]     led_next, oeb_next;
    logic [31:0]    rdata;
    logic           irq_pend;

    wire [1:0] mode     = ctrl[1:0];
    wire       enable   = ctrl[2];
    wire       in_win   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wire [7:0] offset   = wbs_adr_i[7:0];
    wire       access   = wbs_cyc_i & wbs_stb_i & in_win & ~wbs_ack_o;
    wire       wr       = access & wbs_we_i;
    wire       wr_ctrl  = wr && (offset == 8'h00);
    wire       wr_led   = wr && (offset == 8'h04);
    wire       wr_per   = wr && (offset == 8'h08);
    wire       clr_seq  = wr_ctrl | wr_per;
    wire       tick     = (tcnt == period);
    wire       pausable = mode[1];

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_dat_i[31:24], wbs_sel_i[3]};

    // Read-data mux for the register window
    always_comb begin
        rdata = 32'd0;
        case (offset)
            8'h00:   rdata = {29'd0, ctrl};
            8'h04:   rdata = {24'd0, led_data};
            8'h08:   rdata = {8'd0, period};
            8'h0C:   rdata = {20'd0, irq_pend, led_o, btn_db};
            default: rdata = 32'd0;
        endcase
    end

    // Bus handshake and register writes; a held strobe is re-acked every second clock
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            ctrl      <= 3'd0;
            led_data  <= 8'd0;
            period    <= DEF_PERIOD;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'd0;
            if (wr_ctrl && wbs_sel_i[0]) ctrl <= wbs_dat_i[2:0];
            if (wr_led && wbs_sel_i[0])  led_data <= wbs_dat_i[7:0];
            if (wr_per) begin
                if (wbs_sel_i[0]) period[7:0]   <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) period[15:8]  <= wbs_dat_i[15:8];
                if (wbs_sel_i[2]) period[23:16] <= wbs_dat_i[23:16];
            end
        end
    end

    // Two-flop synchroniser then per-button stability counter; any bounce restarts the count
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1  <= 3'd0;
            sync2  <= 3'd0;
            btn_db <= 3'd0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != btn_db[i]) begin
                    if (dcnt[i] == DEB_LAST) begin
                        btn_db[i] <= sync2[i];
                        dcnt[i]   <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Tick counter and pattern generators; reconfiguration restarts both from their start values
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_seq) begin
            tcnt      <= 24'd0;
            chase_pat <= 8'h01;
            count_pat <= 8'h00;
        end else begin
            tcnt <= tick ? 24'd0 : tcnt + 24'd1;
            if (state == ST_RUN && tick) begin
                if (mode == 2'd2) chase_pat <= {chase_pat[6:0], chase_pat[7]};
                if (mode == 2'd3) count_pat <= count_pat + 8'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_OFF;
        else          state <= next_state;
    end

    // Next state and LED drive; drive follows enable directly so outputs lag a write by one clock
    always_comb begin
        next_state = state;
        led_next   = 8'h00;
        oeb_next   = 8'hFF;
        if (!enable) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   next_state = ST_RUN;
                ST_RUN:   if (pausable && btn_db[0]) next_state = ST_PAUSE;
                ST_PAUSE: if (!(pausable && btn_db[0])) next_state = ST_RUN;
                default:  next_state = ST_OFF;
            endcase
            oeb_next = 8'h00;
            case (mode)
                2'd0:    led_next = led_data;
                2'd1:    led_next = {btn_db[1:0], btn_db, btn_db};
                2'd2:    led_next = chase_pat;
                default: led_next = count_pat;
            endcase
        end
    end

    // Registered LED outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            led_o     <= 8'h00;
            led_oeb_o <= 8'hFF;
        end else begin
            led_o     <= led_next;
            led_oeb_o <= oeb_next;
        end
    end

`ifdef BTN_IRQ_EN
    logic [2:0] btn_db_q;
    wire        wr_stat = wr && (offset == 8'h0C) && wbs_sel_i[1] && wbs_dat_i[11];
    wire        db_rise = |(btn_db & ~btn_db_q);

    // Button rising-edge interrupt; a new event beats a same-clock clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            btn_db_q <= 3'd0;
            irq_pend <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (db_rise)      irq_pend <= 1'b1;
            else if (wr_stat) irq_pend <= 1'b0;
        end
    end
`else
    assign irq_pend = 1'b0;
`endif

    assign irq_o = irq_pend;

endmodule

// File: tb/tb_io_led_sequencer.sv
// tb/tb_io_led_sequencer.sv - scoreboard bench for io_led_sequencer
module tb_io_led_sequencer;

    localparam int          DEB  = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [2:0]  btn;
    logic [7:0]  led, oeb;
    logic        irq;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];

`ifdef BTN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    io_led_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .btn_i    (btn),
        .led_o    (led),
        .led_oeb_o(oeb),
        .irq_o    (irq)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [3:0] s, output logic [31:0] rd, output bit acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        acked = 1'b0; rd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                rd = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        bit          acked;
        wb_access(a, d, 1'b1, s, rd, acked);
        tests_run++;
        if (acked !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_ack addr=%h: acked=%0d required=1", a, acked);
        end
    endtask

    task automatic wb_read_check(input string name, input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] rd, e;
        bit          acked;
        exp_q.push_back(expv);
        wb_access(a, 32'd0, 1'b0, 4'hF, rd, acked);
        e = exp_q.pop_front();
        tests_run++;
        if (!acked) begin
            tests_failed++;
            $display("FAIL %s: no ack, required data %h", name, e);
        end else if (rd !== e) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", name, rd, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0; btn = 3'b000;
        step(3);
        tests_run++;
        if ({led, oeb, ack, dat_r, irq} !== {8'h00, 8'hFF, 1'b0, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: led=%h oeb=%h ack=%b dat=%h irq=%b required 00 ff 0 0 0",
                     led, oeb, ack, dat_r, irq);
        end
        rst = 1'b0;
        step(1);
        wb_read_check("reset_ctrl", BASE + 32'h00, 32'd0);
        wb_read_check("reset_period", BASE + 32'h08, 32'd1000);
    endtask

    task automatic test_mirror();
        int  first;
        bit  stayed;
        wb_write(BASE + 32'h00, 32'h5, 4'hF);
        step(1);
        tests_run++;
        if (oeb !== 8'h00 || led !== 8'h00) begin
            tests_failed++;
            $display("FAIL mirror_enable: led=%h oeb=%h required 00 00", led, oeb);
        end
        btn = 3'b111;
        first = -1;
        for (int i = 1; i <= DEB + 6; i++) begin
            step(1);
            if (led === 8'hFF) begin
                first = i;
                break;
            end
        end
        tests_run++;
        if (first < DEB + 2 || first > DEB + 4) begin
            tests_failed++;
            $display("FAIL mirror_latency: clocks=%0d required %0d..%0d", first, DEB + 2, DEB + 4);
        end
        btn = 3'b000;
        step(3);
        btn = 3'b111;
        stayed = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (led !== 8'hFF) stayed = 1'b0;
        end
        tests_run++;
        if (!stayed) begin
            tests_failed++;
            $display("FAIL glitch_reject: led=%h required ff throughout", led);
        end
        btn = 3'b101;
        step(DEB + 8);
        tests_run++;
        if (led !== 8'h6D) begin
            tests_failed++;
            $display("FAIL mirror_101: led=%h required 6d", led);
        end
        wb_read_check("status_mirror", BASE + 32'h0C, {20'd0, IRQ_ON, 8'h6D, 3'b101});
        btn = 3'b000;
        step(DEB + 8);
        tests_run++;
        if (led !== 8'h00) begin
            tests_failed++;
            $display("FAIL mirror_release: led=%h required 00", led);
        end
    endtask

    task automatic test_chase();
        logic [7:0] last, v1, e;
        int         since, changes, bad_gap;
        bit         frozen;
        wb_write(BASE + 32'h00, 32'h0, 4'hF);
        wb_write(BASE + 32'h08, 32'd3, 4'hF);
        wb_write(BASE + 32'h00, 32'h6, 4'hF);
        last = led;
        for (int i = 0; i < 9; i++) exp_q.push_back(32'(8'h01 << (i % 8)));
        since = 0; changes = 0; bad_gap = 0;
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
            step(1);
            since++;
            if (led !== last) begin
                e = exp_q.pop_front();
                tests_run++;
                if (led !== e) begin
                    tests_failed++;
                    $display("FAIL chase_value: got %h required %h", led, e);
                end
                if (changes > 0 && since != 4) bad_gap++;
                changes++;
                since = 0;
                last = led;
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || bad_gap != 0) begin
            tests_failed++;
            $display("FAIL chase_timing: pending=%0d bad_gaps=%0d required 0 0", exp_q.size(), bad_gap);
        end
        exp_q.delete();
        btn = 3'b001;
        step(DEB + 6);
        v1 = led;
        frozen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (led !== v1 || oeb !== 8'h00) frozen = 1'b0;
        end
        tests_run++;
        if (!frozen) begin
            tests_failed++;
            $display("FAIL chase_pause: led=%h oeb=%h required %h 00", led, oeb, v1);
        end
        btn = 3'b000;
        exp_q.push_back({24'd0, v1[6:0], v1[7]});
        for (int i = 0; i < DEB + 12 && led === v1; i++) step(1);
        e = exp_q.pop_front();
        tests_run++;
        if (led !== e) begin
            tests_failed++;
            $display("FAIL chase_resume: got %h required %h", led, e);
        end
    endtask

    task automatic test_count();
        logic [7:0] prev, e;
        int         errs;
        bit         saw_wrap;
        wb_write(BASE + 32'h00, 32'h0, 4'hF);
        wb_write(BASE + 32'h08, 32'd0, 4'hF);
        wb_write(BASE + 32'h00, 32'h7, 4'hF);
        for (int i = 0; i < 10 && led !== 8'h01; i++) step(1);
        tests_run++;
        if (led !== 8'h01) begin
            tests_failed++;
            $display("FAIL count_start: led=%h required 01", led);
        end
        prev = 8'h01; errs = 0; saw_wrap = 1'b0;
        for (int i = 0; i < 260; i++) begin
            exp_q.push_back({24'd0, prev + 8'd1});
            step(1);
            e = exp_q.pop_front();
            if (led !== e) errs++;
            if (prev == 8'hFF && led === 8'h00) saw_wrap = 1'b1;
            prev = led;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL count_increment: errors=%0d required 0", errs);
        end
        tests_run++;
        if (!saw_wrap) begin
            tests_failed++;
            $display("FAIL count_wrap: wrap seen=%0d required 1", saw_wrap);
        end
        wb_write(BASE + 32'h00, 32'h0, 4'hF);
        step(1);
        tests_run++;
        if (led !== 8'h00 || oeb !== 8'hFF) begin
            tests_failed++;
            $display("FAIL disable_off: led=%h oeb=%h required 00 ff", led, oeb);
        end
    endtask

    task automatic test_bus();
        logic [3:0] pat;
        bit         any_ack;
        wb_read_check("status_idle", BASE + 32'h0C, {20'd0, IRQ_ON, 8'h00, 3'b000});
        step(1);
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_width: ack=%b required 0", ack);
        end
        wb_write(BASE + 32'hF0, 32'hFFFF_FFFF, 4'hF);
        wb_read_check("unmapped_read", BASE + 32'hF0, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
        any_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (ack) any_ack = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        tests_run++;
        if (any_ack) begin
            tests_failed++;
            $display("FAIL out_of_window: acked=1 required 0");
        end
        step(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h00;
        for (int i = 3; i >= 0; i--) begin
            step(1);
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        tests_run++;
        if (pat !== 4'b1010) begin
            tests_failed++;
            $display("FAIL held_strobe: ack pattern=%b required 1010", pat);
        end
        step(1);
        wb_write(BASE + 32'h08, 32'h0, 4'hF);
        wb_write(BASE + 32'h08, 32'h00AA_BBCC, 4'b0010);
        wb_read_check("period_bytesel", BASE + 32'h08, 32'h0000_BB00);
        wb_write(BASE + 32'h04, 32'hA5, 4'hF);
        wb_write(BASE + 32'h00, 32'h4, 4'hF);
        step(1);
        tests_run++;
        if (led !== 8'hA5 || oeb !== 8'h00) begin
            tests_failed++;
            $display("FAIL direct_mode: led=%h oeb=%h required a5 00", led, oeb);
        end
        wb_write(BASE + 32'h00, 32'h0, 4'hF);
        step(1);
    endtask

    task automatic test_irq();
        bit ever;
`ifdef BTN_IRQ_EN
        wb_write(BASE + 32'h0C, 32'h800, 4'b0010);
        step(1);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear_initial: irq=%b required 0", irq);
        end
        btn = 3'b100;
        step(DEB + 6);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_set: irq=%b required 1", irq);
        end
        wb_write(BASE + 32'h0C, 32'h800, 4'b0010);
        step(1);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear: irq=%b required 0", irq);
        end
        ever = 1'b0;
`else
        btn = 3'b100;
        ever = 1'b0;
        for (int i = 0; i < DEB + 6; i++) begin
            step(1);
            if (irq !== 1'b0) ever = 1'b1;
        end
        tests_run++;
        if (ever) begin
            tests_failed++;
            $display("FAIL irq_tied: irq went high, required 0");
        end
`endif
        wb_read_check("status_btn2", BASE + 32'h0C, {20'd0, 1'b0, 8'h00, 3'b100});
        btn = 3'b000;
        step(DEB + 6);
    endtask

    task automatic test_reset_mid();
        wb_write(BASE + 32'h00, 32'h5, 4'hF);
        wb_write(BASE + 32'h08, 32'd7, 4'hF);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; dat_w = 32'hFF; sel = 4'hF;
        rst = 1'b1;
        step(1);
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ack: ack=%b required 0", ack);
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
        tests_run++;
        if (oeb !== 8'hFF || led !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_leds: led=%h oeb=%h required 00 ff", led, oeb);
        end
        wb_read_check("reset_mid_ctrl", BASE + 32'h00, 32'd0);
        wb_read_check("reset_mid_led_data", BASE + 32'h04, 32'd0);
        wb_read_check("reset_mid_period", BASE + 32'h08, 32'd1000);
    endtask

    initial begin
        test_reset();
        test_mirror();
        test_chase();
        test_count();
        test_bus();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
